mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module   : mem_arbiter_pkg
// Brief    : Shared FSM encoding and write-enable constant for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] WEA_READ = 4'b0000;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester arbiter for a single-port synchronous data RAM with
//            round-robin fairness and per-requester bus locking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_wea,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_wea,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_wea,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    import mem_arbiter_pkg::*;

    state_t r_state;
    logic   r_rr;
    logic   r_rvalid0;
    logic   r_rvalid1;
    logic   w_gnt0;
    logic   w_gnt1;

    // Grants are gated by rst_n so nothing reaches the RAM while in reset.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (m0_req && m1_req) begin
                        w_gnt0 = ~r_rr;
                        w_gnt1 = r_rr;
                    end else begin
                        w_gnt0 = m0_req;
                        w_gnt1 = m1_req;
                    end
                end
                OWN0:    w_gnt0 = m0_req;
                OWN1:    w_gnt1 = m1_req;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rr      <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0 && (m0_wea == WEA_READ);
            r_rvalid1 <= w_gnt1 && (m1_wea == WEA_READ);
            case (r_state)
                IDLE: begin
                    if (w_gnt0) begin
                        r_rr <= 1'b1;
                        if (m0_lock) r_state <= OWN0;
                    end else if (w_gnt1) begin
                        r_rr <= 1'b0;
                        if (m1_lock) r_state <= OWN1;
                    end
                end
                // Ownership is kept while lock is high, even across idle cycles.
                OWN0:    if (!m0_lock) r_state <= IDLE;
                OWN1:    if (!m1_lock) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_rvalid = r_rvalid0;
    assign m1_rvalid = r_rvalid1;
    assign m0_rdata  = r_rvalid0 ? ram_rdata : '0;
    assign m1_rdata  = r_rvalid1 ? ram_rdata : '0;

    assign ram_addr  = w_gnt1 ? m1_addr  : m0_addr;
    assign ram_wdata = w_gnt1 ? m1_wdata : m0_wdata;
    assign ram_wea   = w_gnt0 ? m0_wea : (w_gnt1 ? m1_wea : WEA_READ);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter with a behavioural data RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              m0_req, m0_lock, m1_req, m1_lock;
    logic [ADDR_W-1:0] m0_addr, m1_addr, ram_addr;
    logic [3:0]        m0_wea, m1_wea, ram_wea;
    logic [DATA_W-1:0] m0_wdata, m1_wdata, ram_wdata, ram_rdata;
    logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wea(m0_wea),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wea(m1_wea),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_wea(ram_wea), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: byte writes, one-cycle synchronous read.
    logic [31:0] ram_mem [0:1023];
    logic [31:0] exp_mem [0:1023];

    function automatic logic [31:0] pat(input logic [9:0] idx);
        return {16'hC0DE, 6'd0, idx};
    endfunction

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_wea[b]) ram_mem[ram_addr[11:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        ram_rdata <= ram_mem[ram_addr[11:2]];
    end

    typedef struct {
        logic        rs;
        logic        r0, l0;
        logic [3:0]  w0;
        logic [16:0] a0;
        logic [31:0] d0;
        logic        r1, l1;
        logic [3:0]  w1;
        logic [16:0] a1;
        logic [31:0] d1;
        logic        eg0, eg1;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    function automatic vec_t mk(input logic rs,
                                input logic r0, input logic l0, input logic [3:0] w0,
                                input logic [16:0] a0, input logic [31:0] d0,
                                input logic r1, input logic l1, input logic [3:0] w1,
                                input logic [16:0] a1, input logic [31:0] d1,
                                input logic eg0, input logic eg1);
        vec_t v;
        v.rs = rs; v.r0 = r0; v.l0 = l0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.l1 = l1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_rvalid();
        exp_t e;
        logic have;
        have = (q0.size() > 0) && (q0[0].due == cyc);
        e.data = '0;
        if (have) e = q0.pop_front();
        chk("m0_rvalid", 32'(m0_rvalid), 32'(have));
        chk("m0_rdata", m0_rdata, have ? e.data : 32'd0);
        have = (q1.size() > 0) && (q1[0].due == cyc);
        e.data = '0;
        if (have) e = q1.pop_front();
        chk("m1_rvalid", 32'(m1_rvalid), 32'(have));
        chk("m1_rdata", m1_rdata, have ? e.data : 32'd0);
    endtask

    task automatic book(input logic [3:0] w, input logic [16:0] a, input logic [31:0] d,
                        input int who);
        exp_t e;
        if (w == 4'b0000) begin
            e.due  = cyc + 1;
            e.data = exp_mem[a[11:2]];
            if (who == 0) q0.push_back(e);
            else          q1.push_back(e);
        end else begin
            for (int b = 0; b < 4; b++)
                if (w[b]) exp_mem[a[11:2]][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    // One clock cycle: drive at the falling edge, check just after.
    task automatic step(input vec_t v);
        logic [3:0] ew;
        @(negedge clk);
        rst_n   = v.rs;
        m0_req  = v.r0; m0_lock = v.l0; m0_wea = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req  = v.r1; m1_lock = v.l1; m1_wea = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
        if (!v.rs) begin
            q0.delete();
            q1.delete();
        end
        #1;
        cyc++;
        check_rvalid();
        chk("m0_gnt", 32'(m0_gnt), 32'(v.eg0));
        chk("m1_gnt", 32'(m1_gnt), 32'(v.eg1));
        ew = v.eg0 ? v.w0 : (v.eg1 ? v.w1 : 4'b0000);
        chk("ram_wea", 32'(ram_wea), 32'(ew));
        if (v.eg0) begin
            chk("ram_addr", 32'(ram_addr), 32'(v.a0));
            book(v.w0, v.a0, v.d0, 0);
        end
        if (v.eg1) begin
            chk("ram_addr", 32'(ram_addr), 32'(v.a1));
            book(v.w1, v.a1, v.d1, 1);
        end
    endtask

    localparam logic [3:0] RD = 4'b0000;
    localparam logic [3:0] WF = 4'b1111;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i] = pat(10'(i));
            exp_mem[i] = pat(10'(i));
        end
        rst_n = 1'b0;
        m0_req = 0; m0_lock = 0; m0_addr = '0; m0_wea = '0; m0_wdata = '0;
        m1_req = 0; m1_lock = 0; m1_addr = '0; m1_wea = '0; m1_wdata = '0;

        //                rs  r0 l0 w0  a0         d0            r1 l1 w1  a1         d1            g0 g1
        // reset with both requesting, then first-cycle grant to m0
        vecs.push_back(mk(0,  1, 0, RD, 17'h00010, 32'h0,        1, 0, RD, 17'h00020, 32'h0,        0, 0));
        vecs.push_back(mk(0,  1, 0, RD, 17'h00010, 32'h0,        1, 0, RD, 17'h00020, 32'h0,        0, 0));
        // contention: alternating grants
        vecs.push_back(mk(1,  1, 0, RD, 17'h00010, 32'h0,        1, 0, RD, 17'h00020, 32'h0,        1, 0));
        vecs.push_back(mk(1,  1, 0, RD, 17'h00010, 32'h0,        1, 0, RD, 17'h00020, 32'h0,        0, 1));
        vecs.push_back(mk(1,  1, 0, RD, 17'h00010, 32'h0,        1, 0, RD, 17'h00020, 32'h0,        1, 0));
        vecs.push_back(mk(1,  1, 0, RD, 17'h00010, 32'h0,        1, 0, RD, 17'h00020, 32'h0,        0, 1));
        vecs.push_back(mk(1,  1, 0, RD, 17'h00010, 32'h0,        0, 0, RD, 17'h00020, 32'h0,        1, 0));
        vecs.push_back(mk(1,  0, 0, RD, 17'h00010, 32'h0,        0, 0, RD, 17'h00020, 32'h0,        0, 0));
        // m1 locked writes for three accesses while m0 waits
        vecs.push_back(mk(1,  1, 0, RD, 17'h00010, 32'h0,        1, 1, WF, 17'h00100, 32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(1,  1, 0, RD, 17'h00010, 32'h0,        1, 1, WF, 17'h00100, 32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(1,  1, 0, RD, 17'h00010, 32'h0,        1, 0, WF, 17'h00100, 32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(1,  1, 0, RD, 17'h00010, 32'h0,        1, 0, RD, 17'h00100, 32'h0,        1, 0));
        vecs.push_back(mk(1,  0, 0, RD, 17'h00010, 32'h0,        1, 0, RD, 17'h00100, 32'h0,        0, 1));
        vecs.push_back(mk(1,  0, 0, RD, 17'h00010, 32'h0,        0, 0, RD, 17'h00100, 32'h0,        0, 0));
        // byte write then read back
        vecs.push_back(mk(1,  1, 0, 4'b0010, 17'h00040, 32'h0000AB00, 0, 0, RD, 17'h0, 32'h0,       1, 0));
        vecs.push_back(mk(1,  1, 0, RD, 17'h00040, 32'h0,        0, 0, RD, 17'h00020, 32'h0,        1, 0));
        vecs.push_back(mk(1,  0, 0, RD, 17'h00040, 32'h0,        0, 0, RD, 17'h00020, 32'h0,        0, 0));
        // lock without request in IDLE has no effect
        vecs.push_back(mk(1,  0, 1, RD, 17'h00010, 32'h0,        1, 0, RD, 17'h00020, 32'h0,        0, 1));
        vecs.push_back(mk(1,  0, 0, RD, 17'h00010, 32'h0,        1, 0, RD, 17'h00020, 32'h0,        0, 1));
        // m0 holds the bus across an idle cycle, releases, then m1 proceeds
        vecs.push_back(mk(1,  1, 1, RD, 17'h00010, 32'h0,        0, 0, RD, 17'h00020, 32'h0,        1, 0));
        vecs.push_back(mk(1,  0, 1, RD, 17'h00010, 32'h0,        1, 0, RD, 17'h00020, 32'h0,        0, 0));
        vecs.push_back(mk(1,  0, 0, RD, 17'h00010, 32'h0,        1, 0, RD, 17'h00020, 32'h0,        0, 0));
        vecs.push_back(mk(1,  0, 0, RD, 17'h00010, 32'h0,        1, 0, RD, 17'h00020, 32'h0,        0, 1));
        // leave rr pointing at m1 before the reset-mid-read sequence
        vecs.push_back(mk(1,  1, 0, RD, 17'h00010, 32'h0,        0, 0, RD, 17'h00020, 32'h0,        1, 0));
        vecs.push_back(mk(1,  0, 0, RD, 17'h00010, 32'h0,        0, 0, RD, 17'h00020, 32'h0,        0, 0));

        foreach (vecs[i]) step(vecs[i]);

        // Reset pulsed between a granted locked read and its capture edge.
        step(mk(1, 1, 1, RD, 17'h00010, 32'h0, 0, 0, RD, 17'h00020, 32'h0, 1, 0));
        rst_n = 1'b0; m0_req = 1'b0; m0_lock = 1'b0;
        q0.delete();
        #1;
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_ram_wea", 32'(ram_wea), 32'd0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        #1;
        rst_n = 1'b1;
        // After reset: IDLE with rr=0, so m0 wins contention; lone m1 is served.
        step(mk(1, 1, 0, RD, 17'h00010, 32'h0, 1, 0, RD, 17'h00020, 32'h0, 1, 0));
        step(mk(1, 0, 0, RD, 17'h00010, 32'h0, 0, 0, RD, 17'h00020, 32'h0, 0, 0));
        step(mk(1, 0, 0, RD, 17'h00010, 32'h0, 1, 0, RD, 17'h00020, 32'h0, 0, 1));
        step(mk(1, 0, 0, RD, 17'h00010, 32'h0, 0, 0, RD, 17'h00020, 32'h0, 0, 0));
        // The byte write must have touched byte 1 only.
        chk("byte_write_word", ram_mem[16], {pat(10'd16)[31:16], 8'hAB, pat(10'd16)[7:0]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
